// File: rtl/seq_div.sv
// ============================================================================
//  Module   : seq_div
//  Purpose  : Sequential restoring divider. It produces one quotient bit
//             per clock, MSB first, and takes BIT_WIDTH cycles per division.
//             A zero divisor skips the calculation and completes on the
//             next cycle with div_by_zero set.
//  Options  : DIV_SIGNED_EN - when defined, all operands and results are
//             two's complement and results truncate toward zero.
//             Unsigned operation is the default.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] dividend,
    input  logic [BIT_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] quotient,
    output logic [BIT_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int                c_CW   = $clog2(BIT_WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [BIT_WIDTH-1:0]   r_rem;   // partial remainder, always < divisor
    logic [BIT_WIDTH-1:0]   r_dvd;   // dividend bits shift out, quotient bits shift in
    logic [BIT_WIDTH-1:0]   r_dvs;   // latched divisor (magnitude)
    logic [c_CW-1:0]        r_cnt;

    // The shifted partial remainder is one bit wider than the operands so
    // the compare against the divisor can never overflow.
    logic [BIT_WIDTH:0]     w_shift;
    logic                   w_ge;
    logic [BIT_WIDTH-1:0]   w_sub;
    logic [BIT_WIDTH-1:0]   w_rem_next;
    logic [BIT_WIDTH-1:0]   w_q_raw;
    logic [BIT_WIDTH-1:0]   w_dvd_mag;
    logic [BIT_WIDTH-1:0]   w_dvs_mag;
    logic [BIT_WIDTH-1:0]   w_q_fin;
    logic [BIT_WIDTH-1:0]   w_r_fin;

    assign w_shift    = {r_rem, r_dvd[BIT_WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    // True difference is below the divisor, so it fits in BIT_WIDTH bits.
    assign w_sub      = w_shift[BIT_WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_sub : w_shift[BIT_WIDTH-1:0];
    assign w_q_raw    = {r_dvd[BIT_WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    logic                   r_neg_q; // operand signs differ
    logic                   r_neg_r; // dividend negative

    // Divide magnitudes; the most negative value maps to itself, which read
    // as unsigned is its correct magnitude.
    assign w_dvd_mag = dividend[BIT_WIDTH-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[BIT_WIDTH-1]  ? -divisor  : divisor;
    assign w_q_fin   = r_neg_q ? -w_q_raw    : w_q_raw;
    assign w_r_fin   = r_neg_r ? -w_rem_next : w_rem_next;

    // Remember the result signs when an operation is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start && (r_state != CALC)) begin
            r_neg_q <= dividend[BIT_WIDTH-1] ^ divisor[BIT_WIDTH-1];
            r_neg_r <= dividend[BIT_WIDTH-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_fin   = w_q_raw;
    assign w_r_fin   = w_rem_next;
`endif

    // Control FSM, datapath iteration and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        r_dvd <= w_dvd_mag;
                        r_dvs <= w_dvs_mag;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            // Nothing to iterate: report at once.
                            r_state     <= FIN;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            busy    <= 1'b1;
                        end
                    end else if (r_state == FIN) begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_q_raw;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state     <= FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= w_q_fin;
                        remainder   <= w_r_fin;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Self-checking bench for seq_div (BIT_WIDTH = 8). It applies a
//             table of known vectors, hand-written multi-cycle sequences,
//             and random operands against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_div #(.BIT_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain integer division with the documented zero-divisor result.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa, sb, sq, sr;
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (sb == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            q  = W'(sq);
            r  = W'(sr);
            z  = 1'b0;
        end
    endfunction

    // Start was set up at the previous negedge; the next posedge accepts it.
    task automatic finish_div(output logic [W-1:0] q, output logic [W-1:0] r,
                              output logic z, output int lat, output int nbusy);
        @(posedge clk);
        lat   = 0;
        nbusy = 0;
        q     = '0;
        r     = '0;
        z     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                q   = quotient;
                r   = remainder;
                z   = div_by_zero;
                break;
            end
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z, output int lat, output int nbusy);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        finish_div(q, r, z, lat, nbusy);
    endtask

    task automatic check_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        logic         z, ez;
        int           lat, nb;
        model(a, b, eq, er, ez);
        run_div(a, b, q, r, z, lat, nb);
        check("rand_quotient",  32'(q), 32'(eq));
        check("rand_remainder", 32'(r), 32'(er));
        check("rand_dbz",       32'(z), 32'(ez));
        check("rand_latency",   32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q, r, q1, r1, q2, r2, eq, er;
        logic         z, ez;
        int           lat, nb, ndone, d1, d2;

`ifdef DIV_SIGNED_EN
        tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});
        tbl.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
        tbl.push_back('{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1});
        tbl.push_back('{8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0});
        tbl.push_back('{8'h81, 8'h7F, 8'hFF, 8'h00, 1'b0});
`else
        tbl.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
        tbl.push_back('{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1});
        tbl.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
        tbl.push_back('{8'd200, 8'd3, 8'd66, 8'd2, 1'b0});
        tbl.push_back('{8'd0, 8'd9, 8'd0, 8'd0, 1'b0});
        tbl.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
        tbl.push_back('{8'd7, 8'd9, 8'd0, 8'd7, 1'b0});
        tbl.push_back('{8'd128, 8'd2, 8'd64, 8'd0, 1'b0});
`endif

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",      32'(busy), 32'd0);
        check("reset_done",      32'(done), 32'd0);
        check("reset_quotient",  32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz",       32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // Known vectors, including the zero divisor followed by a clearing one.
        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, q, r, z, lat, nb);
            check("tbl_quotient",  32'(q), 32'(tbl[i].q));
            check("tbl_remainder", 32'(r), 32'(tbl[i].r));
            check("tbl_dbz",       32'(z), 32'(tbl[i].z));
            check("tbl_latency",   32'(lat), (tbl[i].b == '0) ? 32'd1 : 32'(W + 1));
            check("tbl_busy_cycles", 32'(nb), (tbl[i].b == '0) ? 32'd0 : 32'(W));
            @(negedge clk);
            check("tbl_done_one_cycle", 32'(done), 32'd0);
            check("tbl_result_hold",    32'(quotient), 32'(tbl[i].q));
        end

        // Start during CALC is ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(posedge clk);
        ndone = 0; lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; dividend = '0; divisor = '0; end
            if (c == 4) begin start = 1'b1; dividend = 8'd9; divisor = 8'd9; end
            if (c == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = c; q = quotient; r = remainder; end
            end
        end
        model(8'd200, 8'd3, eq, er, ez);
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_latency",    32'(lat), 32'(W + 1));
        check("ignore_quotient",   32'(q), 32'(eq));
        check("ignore_remainder",  32'(r), 32'(er));

        // Back-to-back: second start presented in the first FIN cycle.
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(posedge clk);
        d1 = 0; d2 = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                if (d1 == 0) begin
                    d1 = c; q1 = quotient; r1 = remainder;
                    start = 1'b1; dividend = 8'd17; divisor = 8'd4;
                end else begin
                    d2 = c; q2 = quotient; r2 = remainder;
                    break;
                end
            end else if (d1 != 0 && c == d1 + 1) begin
                start = 1'b0;
            end
        end
        check("b2b_first_latency", 32'(d1), 32'(W + 1));
        check("b2b_gap",           32'(d2 - d1), 32'(W + 1));
        check("b2b_q1", 32'(q1), 32'd10);
        check("b2b_r1", 32'(r1), 32'd0);
        check("b2b_q2", 32'(q2), 32'd4);
        check("b2b_r2", 32'(r2), 32'd1);

        // Reset in the middle of a calculation.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy",      32'(busy), 32'd0);
        check("midrst_done",      32'(done), 32'd0);
        check("midrst_quotient",  32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        start = 1'b1;
        ndone = 0; nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nb++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_start_ignored", 32'(nb), 32'd0);
        // Release reset with start already high: the first edge accepts it.
        rst = 1'b0; dividend = 8'd100; divisor = 8'd7;
        finish_div(q, r, z, lat, nb);
        check("postrst_latency",   32'(lat), 32'(W + 1));
        check("postrst_quotient",  32'(q), 32'd14);
        check("postrst_remainder", 32'(r), 32'd2);

        // Random operands with occasional zero divisors.
        for (int i = 0; i < 40; i++) begin
            check_div(W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, giving the operand, quotient and remainder width (BIT_WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled on the rising edge of clk.
REQ-005 The block SHALL have port dividend, input, BIT_WIDTH bits: numerator; sampled when start is accepted.
REQ-006 The block SHALL have port divisor, input, BIT_WIDTH bits: denominator; sampled when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the results are valid.
REQ-009 The block SHALL have port quotient, output, BIT_WIDTH bits: registered result.
REQ-010 The block SHALL have port remainder, output, BIT_WIDTH bits: registered result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: set with done when the latched divisor was 0.

Function
REQ-012 The state machine SHALL have exactly three states, IDLE, CALC and FIN, and SHALL leave reset in IDLE.
REQ-013 IDLE or FIN with start=1 SHALL latch the operands, clear the bit counter and go to CALC, or go to FIN directly if divisor==0.
REQ-014 IDLE with start=0 SHALL stay in IDLE; FIN with start=0 SHALL go to IDLE.
REQ-015 CALC SHALL be restoring division, one quotient bit per cycle, MSB first, for exactly BIT_WIDTH cycles.
REQ-016 Each CALC cycle SHALL shift the partial remainder left, shift in the next dividend bit, and compare against the divisor.
REQ-017 If partial remainder >= divisor, the CALC cycle SHALL subtract the divisor and set the quotient bit to 1; otherwise it SHALL leave the remainder and set the quotient bit to 0.
REQ-018 The partial remainder SHALL be BIT_WIDTH+1 bits wide internally, so the compare never overflows.
REQ-019 After the last CALC cycle, the block SHALL go to FIN and load quotient and remainder in the same edge.
REQ-020 busy SHALL be high in every CALC cycle and low in IDLE and FIN.
REQ-021 done SHALL be high in the FIN cycle only.
REQ-022 done SHALL go high BIT_WIDTH+1 cycles after the accepting edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-023 start while busy=1 SHALL be ignored; operand changes during CALC SHALL NOT affect the result.
REQ-024 Back-to-back operation SHALL be supported: start asserted in the FIN cycle is accepted, and done can recur every BIT_WIDTH+1 cycles.
REQ-025 A divisor of 0 SHALL give quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-026 quotient, remainder and div_by_zero SHALL hold their values until the next result load; div_by_zero SHALL be cleared when a later division with a nonzero divisor completes.

Reset
REQ-027 When rst is asserted, the block SHALL go to IDLE immediately, regardless of clk.
REQ-028 While rst is asserted, busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be 0.
REQ-029 Reset during CALC SHALL abandon the division with no done pulse.
REQ-030 start SHALL be ignored while rst is high.
REQ-031 The first edge after rst deasserts SHALL accept start.

Configuration
REQ-032 With macro DIV_SIGNED_EN defined, the block SHALL treat dividend, divisor, quotient and remainder as two's complement.
REQ-033 With DIV_SIGNED_EN defined, the block SHALL divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend (truncation toward zero).
REQ-034 With DIV_SIGNED_EN defined, latency SHALL be unchanged, with sign fix-up in the CALC-to-FIN edge.
REQ-035 With DIV_SIGNED_EN defined, most-negative / -1 SHALL wrap to quotient = most-negative value with remainder 0, and div_by_zero SHALL stay 0.
REQ-036 Without DIV_SIGNED_EN, the block SHALL treat all values as unsigned; this is the default.

Verification (BIT_WIDTH=8)
REQ-037 Unsigned: dividend 100, divisor 7, one-cycle start -> busy high 8 cycles; done 9 cycles after the accepting edge; quotient 14, remainder 2, div_by_zero 0.
REQ-038 Divide by zero: dividend 5, divisor 0 -> done 1 cycle after start; quotient 0xFF, remainder 5, div_by_zero 1; the next division 255/1 -> quotient 255, remainder 0, div_by_zero 0.
REQ-039 Start ignored: 200/3 started, start pulsed with 9/9 at CALC cycle 4 -> single done; quotient 66, remainder 2.
REQ-040 Back-to-back: 50/5 then 17/4, the second start asserted in the first FIN cycle -> done pulses 9 cycles apart; results (10, 0) then (4, 1).
REQ-041 Reset mid-op: rst asserted at CALC cycle 3 of 100/7 -> outputs 0 at once, no done; a following 100/7 gives quotient 14, remainder 2.
REQ-042 DIV_SIGNED_EN: -7/2 -> quotient 0xFD, remainder 0xFF; -128/-1 -> quotient 0x80, remainder 0; 7/-2 -> quotient 0xFD, remainder 1.
